// File: rtl/vga_io_write_bridge_if.sv
// CPU IO write bus plus frame-memory write port of the VGA IO write bridge.
// The bridge takes the slave view; the CPU/memory side takes the master view.
interface vga_io_write_bridge_if #(
  parameter int FB_AW = 13
);
  logic [31:0]      iAddr;
  logic [31:0]      iData;
  logic             iWe;
  logic [FB_AW-1:0] oMem_WAddr;
  logic [31:0]      oMem_WData;
  logic             oMem_We;
  logic             iMem_Ready;
  logic [31:0]      oStatus;

  modport slave (
    input  iAddr, iData, iWe, iMem_Ready,
    output oMem_WAddr, oMem_WData, oMem_We, oStatus
  );

  modport master (
    output iAddr, iData, iWe, iMem_Ready,
    input  oMem_WAddr, oMem_WData, oMem_We, oStatus
  );
endinterface

// File: rtl/vga_io_write_bridge.sv
// Buffers CPU frame-buffer writes and fill-engine words in a show-ahead FIFO.
// The FIFO drains to frame memory over a valid/ready handshake.
module vga_io_write_bridge #(
  parameter logic [31:0] BASE_ADDR  = 32'hFFFF_8000,
  parameter logic [31:0] CTRL_ADDR  = 32'hFFFF_7F00,
  parameter int          FB_AW      = 13,
  parameter int          DEPTH_LOG2 = 4
) (
  input logic                  iCLK,
  input logic                  iRST_N,
  vga_io_write_bridge_if.slave bus
);
  localparam int CW = DEPTH_LOG2 + 1;
  localparam int EW = FB_AW + 32;
  localparam logic [CW-1:0]         CNT_FULL = CW'(1 << DEPTH_LOG2);
  localparam logic [CW-1:0]         CNT_ONE  = CW'(1);
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [FB_AW-1:0]      ADDR_ONE = FB_AW'(1);

  typedef enum logic [0:0] {IDLE = 1'b0, FILL = 1'b1} state_t;

  state_t                state_r, state_nxt_s;
  logic [FB_AW-1:0]      fill_addr_r;
  logic [31:0]           fill_data_r;
  logic [15:0]           remaining_r;
  logic                  overflow_r, overflow_nxt_s;
  logic [DEPTH_LOG2-1:0] wr_ptr_r, rd_ptr_r, rd_ptr_nxt_s;
  logic [CW-1:0]         count_r, count_nxt_s, after_pop_s;
  logic [EW-1:0]         mem_r [1 << DEPTH_LOG2];
  logic [EW-1:0]         push_entry_s, head_nxt_s;
  logic [FB_AW-1:0]      waddr_r;
  logic [31:0]           wdata_r;
  logic                  we_r;
  logic [31:0]           status_r;

  logic       frame_hit_s, ctrl_hit_s, pop_s, room_s, cpu_push_s, fill_push_s, push_s;
  logic       cfg_wr_s, start_s, ovf_set_s, ovf_clr_s;
  logic [1:0] ctrl_reg_s;

  assign frame_hit_s = bus.iWe && (bus.iAddr[31:FB_AW+2] == BASE_ADDR[31:FB_AW+2]);
  assign ctrl_hit_s  = bus.iWe && (bus.iAddr[31:4] == CTRL_ADDR[31:4]);
  assign ctrl_reg_s  = bus.iAddr[3:2];

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop_s       = we_r && bus.iMem_Ready;
  assign room_s      = (count_r != CNT_FULL) || pop_s;
  assign cpu_push_s  = frame_hit_s && room_s;
  assign fill_push_s = (state_r == FILL) && !frame_hit_s && room_s;
  assign push_s      = cpu_push_s || fill_push_s;
  assign ovf_set_s   = frame_hit_s && !room_s;
  assign ovf_clr_s   = ctrl_hit_s && (ctrl_reg_s == 2'd3) && bus.iData[0];
  assign cfg_wr_s    = ctrl_hit_s && (state_r == IDLE);
  assign start_s     = cfg_wr_s && (ctrl_reg_s == 2'd2) && (bus.iData[15:0] != 16'd0);
  assign push_entry_s = cpu_push_s ? {bus.iAddr[FB_AW+1:2], bus.iData} : {fill_addr_r, fill_data_r};
  assign overflow_nxt_s = (overflow_r && !ovf_clr_s) || ovf_set_s;

  // Next occupancy, read pointer and head entry of the FIFO.
  always_comb begin
    count_nxt_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
    if (pop_s) begin
      rd_ptr_nxt_s = rd_ptr_r + PTR_ONE;
      after_pop_s  = count_r - CNT_ONE;
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
      after_pop_s  = count_r;
    end
    // A push into an otherwise empty FIFO becomes the head directly.
    if (push_s && (after_pop_s == {CW{1'b0}})) begin
      head_nxt_s = push_entry_s;
    end else begin
      head_nxt_s = mem_r[rd_ptr_nxt_s];
    end
  end

  // Fill engine next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_s) state_nxt_s = FILL;
        else         state_nxt_s = IDLE;
      end
      FILL: begin
        if (fill_push_s && (remaining_r == 16'd1)) state_nxt_s = IDLE;
        else                                       state_nxt_s = FILL;
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FIFO storage; contents are qualified by count, so no reset is needed.
  always_ff @(posedge iCLK) begin
    if (push_s) mem_r[wr_ptr_r] <= push_entry_s;
  end

  // FIFO pointers, registered head and status outputs.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wr_ptr_r   <= {DEPTH_LOG2{1'b0}};
      rd_ptr_r   <= {DEPTH_LOG2{1'b0}};
      count_r    <= {CW{1'b0}};
      overflow_r <= 1'b0;
      state_r    <= IDLE;
      waddr_r    <= {FB_AW{1'b0}};
      wdata_r    <= 32'd0;
      we_r       <= 1'b0;
      status_r   <= 32'd0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      rd_ptr_r   <= rd_ptr_nxt_s;
      count_r    <= count_nxt_s;
      overflow_r <= overflow_nxt_s;
      state_r    <= state_nxt_s;
      we_r       <= (count_nxt_s != {CW{1'b0}});
      if (count_nxt_s != {CW{1'b0}}) begin
        waddr_r <= head_nxt_s[EW-1:32];
        wdata_r <= head_nxt_s[31:0];
      end
      status_r <= {16'd0, 8'(count_nxt_s), 5'd0, (state_nxt_s == FILL),
                   (count_nxt_s == CNT_FULL), overflow_nxt_s};
    end
  end

  // Fill configuration registers; only writable while the engine is idle.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      fill_addr_r <= {FB_AW{1'b0}};
      fill_data_r <= 32'd0;
      remaining_r <= 16'd0;
    end else if (cfg_wr_s) begin
      case (ctrl_reg_s)
        2'd0:    fill_addr_r <= bus.iData[FB_AW-1:0];
        2'd1:    fill_data_r <= bus.iData;
        2'd2:    if (start_s) remaining_r <= bus.iData[15:0];
        default: fill_addr_r <= fill_addr_r;
      endcase
    end else if (fill_push_s) begin
      fill_addr_r <= fill_addr_r + ADDR_ONE;
      remaining_r <= remaining_r - 16'd1;
    end
  end

  assign bus.oMem_WAddr = waddr_r;
  assign bus.oMem_WData = wdata_r;
  assign bus.oMem_We    = we_r;
  assign bus.oStatus    = status_r;
endmodule

// File: tb/tb_vga_io_write_bridge.sv
// Directed bench for vga_io_write_bridge: a queue-level model of the frame-write
// stream is compared against the DUT every cycle, plus literal expectations.
module tb_vga_io_write_bridge;
  localparam logic [31:0] BASE = 32'hFFFF_8000;
  localparam logic [31:0] CTRL = 32'hFFFF_7F00;

  logic iCLK   = 1'b0;
  logic iRST_N = 1'b1;

  vga_io_write_bridge_if #(.FB_AW(13)) bus ();

  vga_io_write_bridge #(
    .BASE_ADDR(BASE), .CTRL_ADDR(CTRL), .FB_AW(13), .DEPTH_LOG2(4)
  ) dut (
    .iCLK(iCLK), .iRST_N(iRST_N), .bus(bus.slave)
  );

  always #5 iCLK = ~iCLK;

  int checks = 0;
  int errors = 0;

  // Model: expected FIFO contents in order, plus the fill engine and overflow flag.
  logic [44:0] exp_q[$];
  logic [44:0] popped_q[$];
  bit          m_busy, m_ovf;
  logic [12:0] m_addr;
  logic [31:0] m_data;
  int          m_rem;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_busy = 1'b0; m_ovf = 1'b0; m_addr = 13'd0; m_data = 32'd0; m_rem = 0;
  endtask

  // One clock of the model, using the inputs held during that cycle.
  task automatic model_update();
    logic [31:0] a;
    bit frame, ctrl, pop, room, busy0, set, clr;
    a     = bus.iAddr;
    frame = bus.iWe && (a[31:15] == BASE[31:15]);
    ctrl  = bus.iWe && (a[31:4] == CTRL[31:4]);
    pop   = (exp_q.size() > 0) && bus.iMem_Ready;
    room  = (exp_q.size() < 16) || pop;
    busy0 = m_busy;
    set   = 1'b0;
    clr   = 1'b0;
    if (pop) popped_q.push_back(exp_q.pop_front());
    if (frame) begin
      if (room) exp_q.push_back({a[14:2], bus.iData});
      else      set = 1'b1;
    end else if (busy0 && room) begin
      exp_q.push_back({m_addr, m_data});
      m_addr = m_addr + 13'd1;
      m_rem  = m_rem - 1;
      if (m_rem == 0) m_busy = 1'b0;
    end
    if (ctrl) begin
      case (a[3:2])
        2'd0: if (!busy0) m_addr = bus.iData[12:0];
        2'd1: if (!busy0) m_data = bus.iData;
        2'd2: if (!busy0 && bus.iData[15:0] != 16'd0) begin
                m_busy = 1'b1;
                m_rem  = int'(bus.iData[15:0]);
              end
        default: clr = bus.iData[0];
      endcase
    end
    m_ovf = (m_ovf && !clr) || set;
  endtask

  // Per-cycle comparison of DUT outputs against the model.
  always @(negedge iCLK) begin
    check("valid", 64'(bus.oMem_We), 64'(exp_q.size() > 0));
    check("status", 64'(bus.oStatus),
          64'({16'h0, 8'(exp_q.size()), 5'b0, m_busy, (exp_q.size() == 16), m_ovf}));
    if (exp_q.size() > 0) begin
      check("waddr", 64'(bus.oMem_WAddr), 64'(exp_q[0][44:32]));
      check("wdata", 64'(bus.oMem_WData), 64'(exp_q[0][31:0]));
    end
  end

  task automatic step();
    @(posedge iCLK);
    if (iRST_N) model_update();
    @(negedge iCLK);
  endtask

  task automatic wr(logic [31:0] addr, logic [31:0] data);
    bus.iWe = 1'b1; bus.iAddr = addr; bus.iData = data;
    step();
    bus.iWe = 1'b0; bus.iAddr = 32'd0; bus.iData = 32'd0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while ((exp_q.size() > 0 || m_busy) && k < 200) begin
      step();
      k++;
    end
    check("drain_bound", 64'(k < 200), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus.iWe = 1'b0; bus.iAddr = 32'd0; bus.iData = 32'd0; bus.iMem_Ready = 1'b1;
    model_reset();
    #1 iRST_N = 1'b0;
    repeat (2) @(negedge iCLK);
    iRST_N = 1'b1;
    step();
    check("reset_status", 64'(bus.oStatus), 64'd0);

    // Single write appears one cycle later, then the port goes idle.
    wr(BASE + 32'h10, 32'hA5A5_0001);
    check("single_we", 64'(bus.oMem_We), 64'd1);
    check("single_addr", 64'(bus.oMem_WAddr), 64'd4);
    check("single_data", 64'(bus.oMem_WData), 64'hA5A5_0001);
    step();
    check("single_we_off", 64'(bus.oMem_We), 64'd0);

    // Backpressure: 17 writes into 16 entries, the last is dropped.
    bus.iMem_Ready = 1'b0;
    for (int i = 0; i < 17; i++) wr(BASE + 32'(i * 4), 32'(i));
    check("ovf_status", 64'(bus.oStatus), 64'h0000_1003);
    popped_q.delete();
    bus.iMem_Ready = 1'b1;
    drain();
    check("ovf_count", 64'(popped_q.size()), 64'd16);
    for (int i = 0; i < 16 && i < popped_q.size(); i++)
      check("ovf_order", 64'(popped_q[i]), 64'({13'(i), 32'(i)}));
    wr(CTRL + 32'hC, 32'd1);
    check("ovf_clear", 64'(bus.oStatus), 64'd0);

    // Full FIFO with pop and push in the same cycle keeps count and no overflow.
    bus.iMem_Ready = 1'b0;
    for (int i = 0; i < 16; i++) wr(BASE + 32'(i * 4), 32'h100 + 32'(i));
    check("full_status", 64'(bus.oStatus), 64'h0000_1002);
    popped_q.delete();
    bus.iMem_Ready = 1'b1;
    wr(BASE + 32'h80, 32'hBEEF);
    bus.iMem_Ready = 1'b0;
    check("full_pp_status", 64'(bus.oStatus), 64'h0000_1002);
    bus.iMem_Ready = 1'b1;
    drain();
    check("full_pp_count", 64'(popped_q.size()), 64'd17);
    if (popped_q.size() == 17)
      check("full_pp_last", 64'(popped_q[16]), 64'({13'h20, 32'hBEEF}));

    // Fill wraps around the top of the window; LEN written while busy is ignored.
    popped_q.delete();
    wr(CTRL + 32'h0, 32'h1FFE);
    wr(CTRL + 32'h4, 32'h00FF_00FF);
    wr(CTRL + 32'h8, 32'd4);
    wr(CTRL + 32'h8, 32'd2);
    drain();
    check("fill_count", 64'(popped_q.size()), 64'd4);
    if (popped_q.size() == 4) begin
      check("fill_w0", 64'(popped_q[0]), 64'({13'h1FFE, 32'h00FF_00FF}));
      check("fill_w1", 64'(popped_q[1]), 64'({13'h1FFF, 32'h00FF_00FF}));
      check("fill_w2", 64'(popped_q[2]), 64'({13'h0000, 32'h00FF_00FF}));
      check("fill_w3", 64'(popped_q[3]), 64'({13'h0001, 32'h00FF_00FF}));
    end
    check("fill_done", 64'(bus.oStatus), 64'd0);

    // CPU write mid-fill takes priority and lands between fill words.
    bus.iMem_Ready = 1'b0;
    popped_q.delete();
    wr(CTRL + 32'h0, 32'h100);
    wr(CTRL + 32'h8, 32'd8);
    step();
    step();
    wr(BASE + 32'h40, 32'hC0DE);
    repeat (8) step();
    check("prio_status", 64'(bus.oStatus), 64'h0000_0900);
    bus.iMem_Ready = 1'b1;
    drain();
    check("prio_count", 64'(popped_q.size()), 64'd9);
    if (popped_q.size() == 9) begin
      check("prio_w1", 64'(popped_q[1]), 64'({13'h101, 32'h00FF_00FF}));
      check("prio_cpu", 64'(popped_q[2]), 64'({13'h010, 32'hC0DE}));
      check("prio_w3", 64'(popped_q[3]), 64'({13'h102, 32'h00FF_00FF}));
      check("prio_w8", 64'(popped_q[8]), 64'({13'h107, 32'h00FF_00FF}));
    end

    // Reset in the middle of a fill abandons everything immediately.
    bus.iMem_Ready = 1'b0;
    wr(CTRL + 32'h8, 32'd8);
    repeat (3) step();
    #2 iRST_N = 1'b0;
    #1;
    check("rst_mid_we", 64'(bus.oMem_We), 64'd0);
    check("rst_mid_status", 64'(bus.oStatus), 64'd0);
    model_reset();
    @(negedge iCLK);
    iRST_N = 1'b1;
    bus.iMem_Ready = 1'b1;
    repeat (3) step();
    check("rst_after_status", 64'(bus.oStatus), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
